// File: rtl/rally_controller.sv
// Rally controller: sequences serve / rally / point / game-over for a two-player
// paddle game, detects wall and paddle contacts and keeps the score.
module rally_controller #(
  parameter int Y_MAX          = 319,
  parameter int LEFT_PADDLE_X  = 10,
  parameter int RIGHT_PADDLE_X = 229,
  parameter int PADDLE_HEIGHT  = 40,
  parameter int WIN_SCORE      = 7,
  parameter int SERVE_DELAY    = 30,
  parameter int POINT_DELAY    = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       serveButton,
  input  logic [7:0] ballXValue,
  input  logic [8:0] ballYValue,
  input  logic       direction,
  input  logic [8:0] leftPaddleY,
  input  logic [8:0] rightPaddleY,
  output logic       changeXDirection,
  output logic       changeYDirection,
  output logic       ballRun,
  output logic       ballRecentre,
  output logic [3:0] leftScore,
  output logic [3:0] rightScore,
  output logic       gameOver,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_RALLY     = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [9:0] Y_MAX_W   = 10'(Y_MAX);
  localparam logic [7:0] LEFT_X_W  = 8'(LEFT_PADDLE_X);
  localparam logic [7:0] RIGHT_X_W = 8'(RIGHT_PADDLE_X);
  localparam logic [9:0] HEIGHT_W  = 10'(PADDLE_HEIGHT);
  localparam logic [3:0] WIN_W     = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_W   = 8'(SERVE_DELAY);
  localparam logic [7:0] POINT_W   = 8'(POINT_DELAY);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       xlock_q, xlock_d;
  logic       ylock_q, ylock_d;
  logic [3:0] lscore_q, lscore_d;
  logic [3:0] rscore_q, rscore_d;
  logic       cx_q, cx_d;
  logic       cy_q, cy_d;
  logic       run_q, run_d;
  logic       rec_q, rec_d;
  logic       go_q, go_d;

  // Contact geometry, widened to 10 bits so paddleY+height never wraps.
  logic [9:0] y10, pad_lo, pad_hi;
  logic       y_edge, y_inner, wall_evt;
  logic       contact_l, contact_r, contact, in_range, x_inner;

  // Combinational contact, wall and paddle-range evaluation.
  always_comb begin
    y10       = {1'b0, ballYValue};
    y_edge    = (ballYValue == 9'd0) || (y10 >= Y_MAX_W);
    y_inner   = (ballYValue != 9'd0) && (y10 < Y_MAX_W);
    wall_evt  = y_edge && !ylock_q;
    contact_l = !direction && (ballXValue <= LEFT_X_W) && !xlock_q;
    contact_r = direction && (ballXValue >= RIGHT_X_W) && !xlock_q;
    contact   = contact_l || contact_r;
    pad_lo    = direction ? {1'b0, rightPaddleY} : {1'b0, leftPaddleY};
    pad_hi    = pad_lo + HEIGHT_W - 10'd1;
    in_range  = (y10 >= pad_lo) && (y10 <= pad_hi);
    x_inner   = (ballXValue > LEFT_X_W) && (ballXValue < RIGHT_X_W);
  end

  // Next-state, counter, lock, score and output decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xlock_d  = xlock_q;
    ylock_d  = ylock_q;
    lscore_d = lscore_q;
    rscore_d = rscore_q;
    cx_d     = 1'b0;
    cy_d     = 1'b0;
    rec_d    = 1'b0;
    unique case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (serveButton) begin
          lscore_d = '0;
          rscore_d = '0;
          state_d  = S_SERVE;
          cnt_d    = SERVE_W;
          rec_d    = 1'b1;
        end
      end
      S_SERVE: begin
        if (tick) begin
          if (cnt_q == 8'd0) begin
            state_d = S_RALLY;
            xlock_d = 1'b0;
            ylock_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      S_RALLY: begin
        if (tick) begin
          if (wall_evt) begin
            ylock_d = 1'b1;
          end else if (y_inner) begin
            ylock_d = 1'b0;
          end
          if (contact && !in_range) begin
            // A miss suppresses any wall pulse decided on the same tick.
            if (contact_l) begin
              rscore_d = (rscore_q == WIN_W) ? rscore_q : rscore_q + 4'd1;
            end else begin
              lscore_d = (lscore_q == WIN_W) ? lscore_q : lscore_q + 4'd1;
            end
            state_d = S_POINT;
            cnt_d   = POINT_W;
          end else begin
            cy_d = wall_evt;
            if (contact) begin
              cx_d    = 1'b1;
              xlock_d = 1'b1;
            end else if (x_inner) begin
              xlock_d = 1'b0;
            end
          end
        end
      end
      S_POINT: begin
        if (tick) begin
          if (cnt_q == 8'd0) begin
            if ((lscore_q == WIN_W) || (rscore_q == WIN_W)) begin
              state_d = S_GAME_OVER;
            end else begin
              state_d = S_SERVE;
              cnt_d   = SERVE_W;
              rec_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    run_d = (state_d == S_RALLY);
    go_d  = (state_d == S_GAME_OVER);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      xlock_q  <= 1'b0;
      ylock_q  <= 1'b0;
      lscore_q <= '0;
      rscore_q <= '0;
      cx_q     <= 1'b0;
      cy_q     <= 1'b0;
      run_q    <= 1'b0;
      rec_q    <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xlock_q  <= xlock_d;
      ylock_q  <= ylock_d;
      lscore_q <= lscore_d;
      rscore_q <= rscore_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      run_q    <= run_d;
      rec_q    <= rec_d;
      go_q     <= go_d;
    end
  end

  assign changeXDirection = cx_q;
  assign changeYDirection = cy_q;
  assign ballRun          = run_q;
  assign ballRecentre     = rec_q;
  assign leftScore        = lscore_q;
  assign rightScore       = rscore_q;
  assign gameOver         = go_q;
  assign state            = state_q;

endmodule

// File: tb/tb_rally_controller.sv
// Directed scoreboard bench for rally_controller.
module tb_rally_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       serveButton = 1'b0;
  logic [7:0] ballXValue = '0;
  logic [8:0] ballYValue = '0;
  logic       direction = 1'b0;
  logic [8:0] leftPaddleY = '0;
  logic [8:0] rightPaddleY = '0;
  logic       changeXDirection, changeYDirection, ballRun, ballRecentre, gameOver;
  logic [3:0] leftScore, rightScore;
  logic [2:0] state;

  rally_controller #(
    .Y_MAX(319), .LEFT_PADDLE_X(10), .RIGHT_PADDLE_X(229), .PADDLE_HEIGHT(40),
    .WIN_SCORE(7), .SERVE_DELAY(30), .POINT_DELAY(60)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .serveButton(serveButton),
    .ballXValue(ballXValue), .ballYValue(ballYValue), .direction(direction),
    .leftPaddleY(leftPaddleY), .rightPaddleY(rightPaddleY),
    .changeXDirection(changeXDirection), .changeYDirection(changeYDirection),
    .ballRun(ballRun), .ballRecentre(ballRecentre),
    .leftScore(leftScore), .rightScore(rightScore),
    .gameOver(gameOver), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    string tag;
    int    st, cx, cy, run, rec, ls, rs, go;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_ls = 0;
  int   exp_rs = 0;

  task automatic chk(input string tag, input string f, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, f, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
  task automatic step(input bit tk, input bit sb, input int x, input int y, input bit dir,
                      input int lp, input int rp, input string tag,
                      input int st, input int cx, input int cy, input int rec);
    exp_t e;
    tick = tk; serveButton = sb; direction = dir;
    ballXValue = 8'(x); ballYValue = 9'(y);
    leftPaddleY = 9'(lp); rightPaddleY = 9'(rp);
    e.tag = tag; e.st = st; e.cx = cx; e.cy = cy; e.rec = rec;
    e.run = (st == 2) ? 1 : 0;
    e.go  = (st == 4) ? 1 : 0;
    e.ls = exp_ls; e.rs = exp_rs;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, "state", {1'b0, state}, 4'(e.st));
      chk(e.tag, "cx", {3'b0, changeXDirection}, 4'(e.cx));
      chk(e.tag, "cy", {3'b0, changeYDirection}, 4'(e.cy));
      chk(e.tag, "run", {3'b0, ballRun}, 4'(e.run));
      chk(e.tag, "rec", {3'b0, ballRecentre}, 4'(e.rec));
      chk(e.tag, "ls", leftScore, 4'(e.ls));
      chk(e.tag, "rs", rightScore, 4'(e.rs));
      chk(e.tag, "go", {3'b0, gameOver}, 4'(e.go));
    end
  endtask

  // Neutral ticks: ball mid-field, no events expected.
  task automatic ticks(input int n, input string tag, input int st);
    for (int i = 0; i < n; i++) step(1, 0, 100, 100, 0, 0, 0, tag, st, 0, 0, 0);
  endtask

  task automatic serve_to_rally(input string tag);
    ticks(30, {tag, "_serve_hold"}, 1);
    step(1, 0, 100, 100, 0, 0, 0, {tag, "_rally_entry"}, 2, 0, 0, 0);
  endtask

  task automatic point_to_rally(input string tag);
    ticks(60, {tag, "_point_hold"}, 3);
    step(1, 0, 100, 100, 0, 0, 0, {tag, "_reserve"}, 1, 0, 0, 1);
    serve_to_rally(tag);
  endtask

  task automatic right_miss(input string tag);
    exp_ls++;
    step(1, 0, 229, 200, 1, 0, 0, tag, 3, 0, 0, 0);
  endtask

  task automatic left_miss(input string tag);
    exp_rs++;
    step(1, 0, 10, 200, 0, 80, 0, tag, 3, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, "reset", 0, 0, 0, 0);
    reset = 1'b0;
    step(0, 0, 100, 100, 0, 0, 0, "idle_hold", 0, 0, 0, 0);

    // Serve from IDLE is sampled without a tick
    step(0, 1, 100, 100, 0, 0, 0, "serve_idle", 1, 0, 0, 1);
    step(0, 0, 100, 100, 0, 0, 0, "serve_no_tick", 1, 0, 0, 0);
    serve_to_rally("first");

    // Serve ignored in RALLY; contact ignored without tick
    step(0, 1, 100, 100, 0, 0, 0, "serve_in_rally", 2, 0, 0, 0);
    step(0, 0, 229, 100, 1, 0, 80, "no_tick_contact", 2, 0, 0, 0);

    // Right paddle hit, then lock holds
    step(1, 0, 229, 100, 1, 0, 80, "right_hit", 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 229, 100, 1, 0, 80, "right_locked", 2, 0, 0, 0);
    step(1, 0, 100, 100, 0, 0, 0, "xlock_clear", 2, 0, 0, 0);

    // Left hit on last paddle row
    step(1, 0, 10, 119, 0, 80, 0, "left_edge_hit", 2, 1, 0, 0);
    step(1, 0, 100, 100, 1, 0, 0, "xlock_clear2", 2, 0, 0, 0);

    // Top wall pulse then lock
    step(1, 0, 100, 0, 1, 0, 0, "top_wall", 2, 0, 1, 0);
    step(1, 0, 100, 0, 1, 0, 0, "top_locked", 2, 0, 0, 0);
    step(1, 0, 100, 100, 1, 0, 0, "ylock_clear", 2, 0, 0, 0);

    // Bottom wall and right hit on the same tick
    step(1, 0, 229, 319, 1, 0, 300, "wall_and_hit", 2, 1, 1, 0);
    step(1, 0, 100, 100, 0, 0, 0, "locks_clear", 2, 0, 0, 0);

    // Paddle range near the top of the 9-bit space does not wrap
    step(1, 0, 229, 510, 1, 0, 500, "no_wrap_hit", 2, 1, 1, 0);
    step(1, 0, 100, 100, 0, 0, 0, "locks_clear2", 2, 0, 0, 0);

    // Left miss one row past the paddle
    exp_rs++;
    step(1, 0, 10, 120, 0, 80, 0, "left_miss_edge", 3, 0, 0, 0);
    step(0, 1, 100, 100, 0, 0, 0, "serve_in_point", 3, 0, 0, 0);
    point_to_rally("pt1");

    // Left miss far from the paddle
    left_miss("left_miss");
    point_to_rally("pt2");

    // Right miss at the bottom wall: no wall pulse
    exp_ls++;
    step(1, 0, 229, 319, 1, 0, 0, "miss_over_wall", 3, 0, 0, 0);
    point_to_rally("pt3");

    // Bring left score to 6, then the winning miss
    while (exp_ls < 6) begin
      right_miss("right_miss");
      point_to_rally("ptn");
    end
    right_miss("win_miss");
    ticks(60, "final_point_hold", 3);
    step(1, 0, 100, 100, 0, 0, 0, "game_over", 4, 0, 0, 0);
    ticks(3, "game_over_hold", 4);

    // New game from GAME_OVER
    exp_ls = 0; exp_rs = 0;
    step(0, 1, 100, 100, 0, 0, 0, "restart", 1, 0, 0, 1);
    serve_to_rally("g2");

    // Scores 3/2 then reset mid-rally
    for (int i = 0; i < 3; i++) begin
      right_miss("g2_rmiss");
      point_to_rally("g2r");
    end
    for (int i = 0; i < 2; i++) begin
      left_miss("g2_lmiss");
      point_to_rally("g2l");
    end
    reset = 1'b1;
    exp_ls = 0; exp_rs = 0;
    step(1, 0, 229, 100, 1, 0, 80, "reset_mid_rally", 0, 0, 0, 0);
    reset = 1'b0;
    step(1, 0, 100, 100, 0, 0, 0, "post_reset_idle", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rally_controller.md
RALLY_CONTROLLER -- requirements
Module: rally_controller

Interface
REQ-001 SHALL have parameter Y_MAX, default 319, bottom playfield row; the top row is 0.
REQ-002 SHALL have parameter LEFT_PADDLE_X, default 10, left paddle contact column.
REQ-003 SHALL have parameter RIGHT_PADDLE_X, default 229, right paddle contact column.
REQ-004 SHALL have parameter PADDLE_HEIGHT, default 40, paddle span in rows starting at paddle Y.
REQ-005 SHALL have parameter WIN_SCORE, default 7, points that end the game.
REQ-006 SHALL have parameter SERVE_DELAY, default 30, ticks spent in SERVE.
REQ-007 SHALL have parameter POINT_DELAY, default 60, ticks spent in POINT.
REQ-008 SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-009 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-010 SHALL have port tick, input, 1, one-cycle ball-update strobe.
REQ-011 SHALL have port serveButton, input, 1, debounced one-cycle pulse.
REQ-012 SHALL have port ballXValue, input, 8, ball column.
REQ-013 SHALL have port ballYValue, input, 9, ball row.
REQ-014 SHALL have port direction, input, 1, ball direction: 1 = right, 0 = left.
REQ-015 SHALL have port leftPaddleY, input, 9, top row of the left paddle.
REQ-016 SHALL have port rightPaddleY, input, 9, top row of the right paddle.
REQ-017 SHALL have port changeXDirection, output, 1, one-cycle pulse to the ball mover.
REQ-018 SHALL have port changeYDirection, output, 1, one-cycle pulse to the ball mover.
REQ-019 SHALL have port ballRun, output, 1, ball motion enable; high only in RALLY.
REQ-020 SHALL have port ballRecentre, output, 1, one-cycle pulse that returns the ball to its start position.
REQ-021 SHALL have port leftScore, output, 4, left player points.
REQ-022 SHALL have port rightScore, output, 4, right player points.
REQ-023 SHALL have port gameOver, output, 1, high in GAME_OVER.
REQ-024 SHALL have port state, output, 3, current state: IDLE=0, SERVE=1, RALLY=2, POINT=3, GAME_OVER=4.

Function
REQ-025 SHALL register every output; all decisions are evaluated only in cycles with tick=1, except serveButton, which is sampled every cycle.
REQ-026 SHALL, in IDLE or GAME_OVER, respond to serveButton=1 by clearing both scores, entering SERVE and pulsing ballRecentre.
REQ-027 SHALL, on SERVE entry, load the 8-bit delay counter with SERVE_DELAY and decrement it on each tick; the tick that finds the counter at 0 enters RALLY.
REQ-028 SHALL, in RALLY, pulse changeYDirection when (ballYValue==0 or ballYValue>=Y_MAX) and yLock=0, then set yLock; yLock clears when 0<ballYValue<Y_MAX.
REQ-029 SHALL detect left contact when direction=0, ballXValue<=LEFT_PADDLE_X and xLock=0; right contact when direction=1, ballXValue>=RIGHT_PADDLE_X and xLock=0.
REQ-030 SHALL, on contact, compare ballYValue with the paddle range [paddleY, paddleY+PADDLE_HEIGHT-1] using 10-bit unsigned arithmetic (no wrap); in range = hit, else miss.
REQ-031 SHALL, on a hit, pulse changeXDirection and set xLock; xLock clears when LEFT_PADDLE_X<ballXValue<RIGHT_PADDLE_X.
REQ-032 SHALL, on a miss, credit the opponent: a left miss increments rightScore and a right miss increments leftScore; it then enters POINT with no direction pulses that cycle.
REQ-033 SHALL treat a hit and a Y-wall event on the same tick as legal and issue both pulses in the same cycle; a miss overrides any wall pulse.
REQ-034 SHALL, on POINT entry, load the delay counter with POINT_DELAY; at count 0 it enters GAME_OVER if either score equals WIN_SCORE, else enters SERVE and pulses ballRecentre.
REQ-035 SHALL never increment a score beyond WIN_SCORE.
REQ-036 SHALL clear xLock and yLock on every RALLY entry.
REQ-037 SHALL make every pulse output exactly one clock wide, appearing in the cycle after the deciding tick.
REQ-038 SHALL ignore serveButton in SERVE, RALLY and POINT.

Reset
REQ-039 SHALL, while reset=1 at a clock edge, enter IDLE and set: scores 0, counter 0, locks 0, all pulse outputs 0, ballRun 0, gameOver 0, state 0; this holds from any state, mid-rally included.

Verification
REQ-040 SHALL cover: reset, then serveButton, then 30 ticks -> state 1 with ballRecentre pulsed once, then state 2 with ballRun=1.
REQ-041 SHALL cover: RALLY, direction=1, X=229, Y=100, rightPaddleY=80 on a tick -> one changeXDirection pulse; repeated ticks at X=229 -> no further pulse.
REQ-042 SHALL cover: RALLY, direction=0, X=10, Y=200, leftPaddleY=80 -> rightScore=1, state 3, no pulses; after 60 ticks -> state 1 with ballRecentre pulsed.
REQ-043 SHALL cover: Y=319 and a right paddle hit on the same tick -> changeXDirection and changeYDirection both pulse in the same cycle.
REQ-044 SHALL cover: leftScore=6 plus a right miss -> leftScore=7; after 60 ticks -> state 4 with gameOver=1; serveButton -> scores 0, state 1.
REQ-045 SHALL cover: reset asserted mid-RALLY with scores 3/2 -> next edge gives state 0, scores 0 and ballRun 0.
